// File: rtl/pipe_pkg.sv
// Shared types and constants for pcpu pipeline stage buffers.
// Stage bundle widths, bubble encodings and state helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int INST_W   = 32;
  localparam int PC_W     = 32;
  localparam int REG_W    = 32;
  localparam int CTRL_W   = 16;
  localparam int IF_ID_W  = INST_W + PC_W;
  localparam int ID_EX_W  = PC_W + 3 * REG_W + CTRL_W;
  localparam int EX_MEM_W = PC_W + 2 * REG_W + CTRL_W;
  localparam int MEM_WB_W = 2 * REG_W + CTRL_W;

  // addi x0, x0, 0 in the inst field, PC zeroed
  localparam logic [INST_W-1:0]  NOP_INST  = 32'h0000_0013;
  localparam logic [IF_ID_W-1:0] NOP_IF_ID = {NOP_INST, {PC_W{1'b0}}};

  function automatic logic st_main_v(state_t s);
    return s != ST_EMPTY;
  endfunction

  function automatic logic st_skid_v(state_t s);
    return s == ST_TWO;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for stage performance events.
// Sticks at all-ones; cleared by synchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // count events, holding at the maximum value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready, optional skid entry,
// flush-to-bubble and saturating stall/kill counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] FLUSH_DATA = '0,
  parameter bit               SKID       = 1'b1,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_skid_q;

  logic w_main_v;
  logic w_skid_v;
  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_in;
  logic w_ld_skid;
  logic w_ld_from_skid;
  logic w_ld_flush;
  logic w_stall_inc;
  logic w_kill_inc;

  assign w_main_v = st_main_v(r_state);
  assign w_skid_v = st_skid_v(r_state);

  // skid mode: ready comes from state only, never from out_ready
  if (SKID) begin : g_rdy_skid
    assign in_ready = !w_skid_v && !reset;
  end else begin : g_rdy_flow
    assign in_ready = (!w_main_v || out_ready) && !reset;
  end

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = w_main_v && out_ready;

  // next state and data-path load selects
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_in        = 1'b0;
    w_ld_skid      = 1'b0;
    w_ld_from_skid = 1'b0;
    w_ld_flush     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_ld_flush  = 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_ld_in     = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_in = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in_fire && SKID) begin
            w_state_nxt = ST_TWO;
            w_ld_skid   = 1'b1;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt    = ST_ONE;
            w_ld_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // main entry: bubble on reset/flush, else newest or skid payload
  always_ff @(posedge clk) begin
    if (reset || w_ld_flush) begin
      r_main <= FLUSH_DATA;
    end else if (w_ld_in) begin
      r_main <= in_data;
    end else if (w_ld_from_skid) begin
      r_main <= w_skid_q;
    end
  end

  if (SKID) begin : g_skid
    logic [WIDTH-1:0] r_skid;
    // skid entry captures input while main is stalled
    always_ff @(posedge clk) begin
      if (reset) begin
        r_skid <= FLUSH_DATA;
      end else if (w_ld_skid) begin
        r_skid <= in_data;
      end
    end
    assign w_skid_q = r_skid;
  end else begin : g_noskid
    assign w_skid_q = FLUSH_DATA;
    a_no_two: assert property (
      @(posedge clk) disable iff (reset) r_state != ST_TWO
    );
  end

  assign out_valid = w_main_v;
  assign out_data  = r_main;

  assign w_stall_inc = w_main_v && !out_ready && !flush;
  assign w_kill_inc  = flush && (w_main_v || w_skid_v);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_kill_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_kill_inc),
    .cnt   (kill_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid (4-bit counters) and
// flow-through (16-bit counters) instances against a queue model.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam logic [63:0] FA = NOP_IF_ID;
  localparam logic [63:0] FB = 64'hFFFF_0000_FFFF_0000;
  localparam int MA = 15;
  localparam int MB = 65535;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        a_in_valid = 1'b0, a_in_ready;
  logic [63:0] a_in_data = '0, a_out_data;
  logic        a_flush = 1'b0, a_out_valid, a_out_ready = 1'b0;
  logic [3:0]  a_stall, a_kill;

  logic        b_in_valid = 1'b0, b_in_ready;
  logic [63:0] b_in_data = '0, b_out_data;
  logic        b_flush = 1'b0, b_out_valid, b_out_ready = 1'b0;
  logic [15:0] b_stall, b_kill;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] la = FA;
  logic [63:0] lb = FB;
  int sa = 0, ka = 0, sb = 0, kb = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .WIDTH(64), .FLUSH_DATA(FA), .SKID(1'b1), .CNT_W(4)
  ) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data),
    .stall_cnt(a_stall), .kill_cnt(a_kill)
  );

  pipe_stage_buf #(
    .WIDTH(64), .FLUSH_DATA(FB), .SKID(1'b0), .CNT_W(16)
  ) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data),
    .stall_cnt(b_stall), .kill_cnt(b_kill)
  );

  // advance one clock; the queue model follows the handshake rules
  task automatic tick();
    bit rdy;
    @(posedge clk);
    rdy = !reset && (qa.size() < 2);
    if (reset) begin
      qa.delete(); sa = 0; ka = 0; la = FA;
    end else if (a_flush) begin
      if (qa.size() != 0 && ka < MA) ka++;
      qa.delete(); la = FA;
    end else begin
      if (qa.size() != 0 && !a_out_ready && sa < MA) sa++;
      if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());
      if (a_in_valid && rdy) qa.push_back(a_in_data);
      if (qa.size() != 0) la = qa[0];
    end
    rdy = !reset && (qb.size() == 0 || b_out_ready);
    if (reset) begin
      qb.delete(); sb = 0; kb = 0; lb = FB;
    end else if (b_flush) begin
      if (qb.size() != 0 && kb < MB) kb++;
      qb.delete(); lb = FB;
    end else begin
      if (qb.size() != 0 && !b_out_ready && sb < MB) sb++;
      if (qb.size() != 0 && b_out_ready) void'(qb.pop_front());
      if (b_in_valid && rdy) qb.push_back(b_in_data);
      if (qb.size() != 0) lb = qb[0];
    end
    #1;
  endtask

  task automatic idle_a();
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_a();
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    a_in_valid = 1'b1; a_in_data = 64'h1234;
    @(negedge clk);
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_in_ready_hi got %b want 0", a_in_ready);
    end
    tick();
    reset = 1'b0; idle_a();
    @(negedge clk);
    n_vec += 10;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_a_ovalid got %b want 0", a_out_valid);
    end
    if (a_out_data !== FA) begin
      n_err++; $display("FAIL rst_a_odata got %h want %h", a_out_data, FA);
    end
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_a_iready got %b want 1", a_in_ready);
    end
    if (a_stall !== 4'd0 || a_kill !== 4'd0) begin
      n_err++; $display("FAIL rst_a_cnt got %0d/%0d want 0/0", a_stall, a_kill);
    end
    if (b_out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_b_ovalid got %b want 0", b_out_valid);
    end
    if (b_out_data !== FB) begin
      n_err++; $display("FAIL rst_b_odata got %h want %h", b_out_data, FB);
    end
    if (b_in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_b_iready got %b want 1", b_in_ready);
    end
    if (b_stall !== 16'd0) begin
      n_err++; $display("FAIL rst_b_stall got %0d want 0", b_stall);
    end
    if (b_kill !== 16'd0) begin
      n_err++; $display("FAIL rst_b_kill got %0d want 0", b_kill);
    end
    if (a_stall !== 4'd0) begin
      n_err++; $display("FAIL rst_a_stall got %0d want 0", a_stall);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [63:0] av[4];
    do_reset();
    for (int k = 0; k < 4; k++)
      av[k] = 64'h0000_0010_0000_0004 + 64'(k) * 64'h0000_0001_0000_0004;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1; a_in_data = av[k]; a_out_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (a_in_ready !== 1'b1) begin
        n_err++; $display("FAIL stream_iready k=%0d got %b want 1", k, a_in_ready);
      end
      if (k > 0) begin
        n_vec++;
        if (a_out_valid !== 1'b1 || a_out_data !== av[k-1]) begin
          n_err++;
          $display("FAIL stream_out k=%0d got %b/%h want 1/%h",
                   k, a_out_valid, a_out_data, av[k-1]);
        end
      end
      tick();
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== av[3]) begin
      n_err++;
      $display("FAIL stream_last got %b/%h want 1/%h", a_out_valid, a_out_data, av[3]);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (a_out_valid !== 1'b0 || a_stall !== 4'd0) begin
      n_err++;
      $display("FAIL stream_end got v=%b st=%0d want v=0 st=0", a_out_valid, a_stall);
    end
  endtask

  task automatic test_skid();
    logic [63:0] offer[8];
    logic        orv[8];
    logic        exp_rdy[8];
    logic        exp_ov[8];
    logic [63:0] exp_od[8];
    do_reset();
    offer   = '{64'hB1, 64'hB2, 64'hB3, 64'hB3, 64'hB3, 64'hB3, 64'h0, 64'h0};
    orv     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_od  = '{FA, 64'hB1, 64'hB1, 64'hB1, 64'hB1, 64'hB2, 64'hB3, 64'hB3};
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (c < 6); a_in_data = offer[c]; a_out_ready = orv[c];
      @(negedge clk);
      n_vec += 2;
      if (a_in_ready !== exp_rdy[c]) begin
        n_err++; $display("FAIL skid_iready c=%0d got %b want %b", c, a_in_ready, exp_rdy[c]);
      end
      if (a_out_valid !== exp_ov[c] || (exp_ov[c] && a_out_data !== exp_od[c])) begin
        n_err++;
        $display("FAIL skid_out c=%0d got %b/%h want %b/%h",
                 c, a_out_valid, a_out_data, exp_ov[c], exp_od[c]);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (a_stall !== 4'd3) begin
      n_err++; $display("FAIL skid_stall got %0d want 3", a_stall);
    end
  endtask

  task automatic test_flush();
    do_reset();
    a_in_valid = 1'b1; a_in_data = 64'hC1; tick();
    a_in_data = 64'hC2; tick();
    a_in_data = 64'hC3; a_flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_two_iready got %b want 0", a_in_ready);
    end
    tick();
    idle_a();
    @(negedge clk);
    n_vec++;
    if (a_out_valid !== 1'b0 || a_out_data !== FA || a_in_ready !== 1'b1 ||
        a_kill !== 4'd1) begin
      n_err++;
      $display("FAIL flush_two got v=%b d=%h r=%b k=%0d want 0/%h/1/1",
               a_out_valid, a_out_data, a_in_ready, a_kill, FA);
    end
    a_in_valid = 1'b1; a_in_data = 64'hF1; tick();
    a_in_data = 64'hF2; a_flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_one_iready got %b want 1", a_in_ready);
    end
    tick();
    idle_a(); a_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (a_out_valid !== 1'b0 || a_out_data !== FA || a_kill !== 4'd2) begin
        n_err++;
        $display("FAIL flush_drop c=%0d got v=%b d=%h k=%0d want 0/%h/2",
                 c, a_out_valid, a_out_data, a_kill, FA);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_flush = 1'b1; tick();
    a_flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_kill !== 4'd0 || a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_empty got k=%0d v=%b want 0/0", a_kill, a_out_valid);
    end
    a_in_valid = 1'b1; a_in_data = 64'hD0; tick();
    a_in_valid = 1'b0; a_flush = 1'b1; tick();
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hD1; tick();
    a_in_valid = 1'b0; tick();
    @(negedge clk);
    n_vec++;
    if (a_kill !== 4'd1 || a_stall !== 4'd1 || a_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_rst got k=%0d s=%0d v=%b want 1/1/1", a_kill, a_stall, a_out_valid);
    end
    reset = 1'b1; a_in_valid = 1'b1; a_in_data = 64'hD2; a_out_ready = 1'b1;
    tick();
    reset = 1'b0; idle_a();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (a_out_valid !== 1'b0 || a_stall !== 4'd0 || a_kill !== 4'd0 ||
          a_out_data !== FA || a_in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mid_rst c=%0d got v=%b s=%0d k=%0d d=%h r=%b",
                 c, a_out_valid, a_stall, a_kill, a_out_data, a_in_ready);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    int e;
    do_reset();
    a_in_valid = 1'b1; a_in_data = 64'hE1; tick();
    a_in_valid = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      e = (k < 15) ? k : 15;
      @(negedge clk);
      n_vec++;
      if (a_stall !== 4'(e)) begin
        n_err++; $display("FAIL sat k=%0d got %0d want %0d", k, a_stall, e);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      a_in_valid  = $urandom_range(0, 1);
      a_in_data   = {$urandom, $urandom};
      a_out_ready = $urandom_range(0, 1);
      a_flush     = ($urandom_range(0, 39) == 0);
      b_in_valid  = $urandom_range(0, 1);
      b_in_data   = {$urandom, $urandom};
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      n_vec += 11;
      if (a_in_ready !== (qa.size() < 2)) begin
        n_err++; $display("FAIL rnd_a_iready c=%0d got %b", c, a_in_ready);
      end
      if (a_out_valid !== (qa.size() != 0) || a_out_data !== la) begin
        n_err++;
        $display("FAIL rnd_a_out c=%0d got %b/%h want %b/%h",
                 c, a_out_valid, a_out_data, qa.size() != 0, la);
      end
      if (a_stall !== 4'(sa)) begin
        n_err++; $display("FAIL rnd_a_stall c=%0d got %0d want %0d", c, a_stall, sa);
      end
      if (a_kill !== 4'(ka)) begin
        n_err++; $display("FAIL rnd_a_kill c=%0d got %0d want %0d", c, a_kill, ka);
      end
      if (b_in_ready !== (!b_out_valid || b_out_ready)) begin
        n_err++; $display("FAIL rnd_b_iready_rel c=%0d got %b", c, b_in_ready);
      end
      if (b_in_ready !== (qb.size() == 0 || b_out_ready)) begin
        n_err++; $display("FAIL rnd_b_iready c=%0d got %b", c, b_in_ready);
      end
      if (b_out_valid !== (qb.size() != 0)) begin
        n_err++; $display("FAIL rnd_b_ovalid c=%0d got %b", c, b_out_valid);
      end
      if (b_out_data !== lb) begin
        n_err++; $display("FAIL rnd_b_odata c=%0d got %h want %h", c, b_out_data, lb);
      end
      if (b_stall !== 16'(sb)) begin
        n_err++; $display("FAIL rnd_b_stall c=%0d got %0d want %0d", c, b_stall, sb);
      end
      if (b_kill !== 16'(kb)) begin
        n_err++; $display("FAIL rnd_b_kill c=%0d got %0d want %0d", c, b_kill, kb);
      end
      if (qb.size() > 1) begin
        n_err++; $display("FAIL rnd_b_depth c=%0d got %0d want <=1", c, qb.size());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
